div_iter: RTL and testbench

//  Multi-cycle 32-bit integer divider serving the EX stage's DIV/DIVU requests.
//  It is the responder side of the ex_top div interface: ex_top drives operands, start and sign mode.

---
 rtl/div_iter_pkg.sv | 35 +++
 rtl/div_iter_if.sv | 50 +++++
 rtl/div_iter.sv | 195 +++++++++++++++++++
 tb/tb_div_iter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_pkg
// Description : Shared constants for the iterative divider. Holds the FSM
//               state encoding, the ready/start level names used on the
//               EX-stage divider handshake, and the default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

    // Default operand width and iteration counter width.
    // The counter width must be able to represent DATA_W itself.
    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    // Divider FSM encoding (2-bit)
    localparam logic [1:0] DIV_FREE    = 2'd0;
    localparam logic [1:0] DIV_BY_ZERO = 2'd1;
    localparam logic [1:0] DIV_ON      = 2'd2;
    localparam logic [1:0] DIV_END     = 2'd3;

    // Handshake level names
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // A request is live when start is asserted and no flush is in progress.
    // The same condition launches an op in FREE and keeps one running in ON.
    function automatic logic div_request_live(input logic start, input logic annul);
        return (start == DIV_START) && !annul;
    endfunction

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_if
// Description : Handshake between the EX stage (master) and the iterative
//               divider (slave).
//   signed_div_i  master->slave  1 = signed DIV, 0 = DIVU
//   opdata1_i     master->slave  dividend
//   opdata2_i     master->slave  divisor
//   start_i       master->slave  request, held until ready_o is seen
//   annul_i       master->slave  flush, aborts the current operation
//   result_o      slave->master  {remainder, quotient}, valid while ready_o
//   ready_o       slave->master  result valid
// Revision    : 1.0 - initial release
// ============================================================================
interface div_iter_if #(
    parameter int DATA_W = 32
) ();

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    // Requester side (EX stage)
    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    // Responder side (divider)
    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );

endinterface : div_iter_if
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Multi-cycle restoring divider for DIV/DIVU. One quotient bit
//               is produced per clock; the result {remainder, quotient} is
//               presented with ready_o until the requester drops start_i.
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   bus   div_iter_if.slave (operands, start, annul, sign mode / result, ready)
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W   // must be able to hold DATA_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    div_iter_if.slave   bus
);

    // ------------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------------
    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [CNT_W-1:0]    cnt;
    // {rem, quo}. The restoring step conceptually shifts a (2*DATA_W+1)-bit
    // register left; only its top DATA_W+1 bits take part in the subtraction,
    // so the extra bit is formed on the fly in 'partial' instead of stored.
    logic [2*DATA_W-1:0] work;
    logic [DATA_W-1:0]   divisor;
    logic                neg_quo;
    logic                neg_rem;
    logic [2*DATA_W-1:0] result;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                live;
    logic                divisor_zero;
    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic                last_step;
    logic                zero_wait_done;
    logic [DATA_W:0]     partial;
    logic                fits;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] work_step;
    logic [DATA_W-1:0]   quo_raw;
    logic [DATA_W-1:0]   rem_raw;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign live         = div_request_live(bus.start_i, bus.annul_i);
    assign divisor_zero = (bus.opdata2_i == '0);

    // Magnitudes are taken only for signed requests. The most negative value
    // maps onto itself, which is the correct unsigned magnitude.
    assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    assign last_step      = (cnt == CNT_W'(DATA_W));
    assign zero_wait_done = (cnt == CNT_W'(1));

    // Restoring step: partial = rem shifted left with the next dividend bit
    // appended. The difference always fits in DATA_W bits when it is kept,
    // because the remainder stays below the divisor.
    assign partial   = work[2*DATA_W-1:DATA_W-1];
    assign fits      = (partial >= {1'b0, divisor});
    assign diff      = partial[DATA_W-1:0] - divisor;
    assign work_step = {(fits ? diff : partial[DATA_W-1:0]), work[DATA_W-2:0], fits};

    // Sign correction: quotient negative when signs differ, remainder takes
    // the dividend's sign. 0x80000000 / -1 wraps back to 0x80000000.
    assign quo_raw = work[DATA_W-1:0];
    assign rem_raw = work[2*DATA_W-1:DATA_W];
    assign quo_fix = neg_quo ? -quo_raw : quo_raw;
    assign rem_fix = neg_rem ? -rem_raw : rem_raw;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_FREE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            DIV_FREE: begin
                if (live) begin
                    state_next = divisor_zero ? DIV_BY_ZERO : DIV_ON;
                end
            end
            // Held for two cycles so divide-by-zero answers with a fixed
            // two-cycle latency from the launching edge.
            DIV_BY_ZERO: begin
                if (zero_wait_done) begin
                    state_next = DIV_END;
                end
            end
            DIV_ON: begin
                if (!live) begin
                    state_next = DIV_FREE;
                end else if (last_step) begin
                    state_next = DIV_END;
                end
            end
            DIV_END: begin
                // start_i held high keeps END: a new op needs start low first.
                if (!live) begin
                    state_next = DIV_FREE;
                end
            end
            default: state_next = DIV_FREE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (live) begin
                        cnt <= '0;
                        if (divisor_zero) begin
                            result <= '0;
                        end else begin
                            // Operands are captured only here; later changes
                            // on the bus are ignored until the next launch.
                            work    <= {{DATA_W{1'b0}}, op1_abs};
                            divisor <= op2_abs;
                            neg_quo <= op1_neg ^ op2_neg;
                            neg_rem <= op1_neg;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    cnt    <= cnt + CNT_W'(1);
                    result <= '0;
                end
                DIV_ON: begin
                    if (live) begin
                        if (last_step) begin
                            result <= {rem_fix, quo_fix};
                        end else begin
                            work <= work_step;
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    // END: result held stable
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. The result is only driven while it is valid, so the bus
    // reads zero in every other state.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.ready_o  = DIV_RESULT_NOT_READY;
        bus.result_o = '0;
        if (state == DIV_END) begin
            bus.ready_o  = DIV_RESULT_READY;
            bus.result_o = result;
        end
    end

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Self-checking bench for div_iter. Expected results are
//               queued when an operation is launched and compared when
//               ready_o rises; latency, hold, annul and reset are checked too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    logic clk;
    logic rst;

    div_iter_if #(.DATA_W(DATA_W)) bus ();

    div_iter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {remainder, quotient}
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Launch one op, wait for ready, compare, hold start 'hold' cycles past
    // ready, then drop start and confirm ready falls.
    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int n;
        int lat_exp;
        logic [63:0] exp;
        exp_q.push_back(model(sgn, a, b));
        lat_exp = (b == 32'd0) ? 2 : DATA_W + 1;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        @(negedge clk);
        // Launch edge has passed; scramble operands, they must be ignored.
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) begin
                n = i;
                break;
            end
        end
        check({tag, "_lat"}, 64'(n), 64'(lat_exp));
        exp = exp_q.pop_front();
        check({tag, "_res"}, bus.result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
            check({tag, "_hold_res"}, bus.result_o, exp);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
    endtask

    initial begin
        int rises;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(bus.ready_o), 64'd0);
        check("rst_res", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          5);
        run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          0);
        run_op("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  0);
        run_op("divu_5_0",     1'b0, 32'd5,          32'd0,          1);
        run_op("div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  0);
        run_op("divu_min_m1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  0);
        run_op("div_m9_m4",    1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFC,  0);
        run_op("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          0);

        // Random cases
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            run_op("rand", 1'($urandom_range(0, 1)), ra, rb, 0);
        end

        // Annul at cycle 10 of ON
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_rdy", 64'(bus.ready_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) rises++;
        end
        check("annul_no_ready", 64'(rises), 64'd0);
        run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, 0);

        // Reset during ON
        @(negedge clk);
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'd77;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        repeat (6) @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_on_rdy", 64'(bus.ready_o), 64'd0);
        check("rst_on_res", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst_77_5", 1'b1, 32'd77, 32'd5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_iter
`default_nettype wire
